// File: rtl/ram_bist_pkg.sv
// Shared definitions for the router FIFO RAM BIST: March C- element table and
// controller state encoding.
package ram_bist_pkg;

    typedef enum logic [2:0] {
        E0 = 3'd0,
        E1 = 3'd1,
        E2 = 3'd2,
        E3 = 3'd3,
        E4 = 3'd4,
        E5 = 3'd5
    } march_elem_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int NUM_ELEMS = 6;

    // One bit per element, indexed by march_elem_e.
    localparam logic [NUM_ELEMS-1:0] ELEM_DOWN   = 6'b011000;
    localparam logic [NUM_ELEMS-1:0] ELEM_HAS_RD = 6'b111110;
    localparam logic [NUM_ELEMS-1:0] ELEM_HAS_WR = 6'b011111;
    localparam logic [NUM_ELEMS-1:0] ELEM_RD_POL = 6'b010100;
    localparam logic [NUM_ELEMS-1:0] ELEM_WR_POL = 6'b001010;

    function automatic logic [1:0] elem_ops(input march_elem_e e);
        return 2'(ELEM_HAS_RD[e]) + 2'(ELEM_HAS_WR[e]);
    endfunction

endpackage

// File: rtl/bist_march_seq.sv
// March C- address/element sequencer: holds the next op to issue and advances
// one op per step, wrapping addresses to the next element's start.
module bist_march_seq
    import ram_bist_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              restart,
    input  logic              step,
    output march_elem_e       elem,
    output logic [ADDR_W-1:0] addr,
    output logic              phase,
    output logic              last
);

    localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(DEPTH - 1);

    logic        elem_end;
    march_elem_e elem_nxt;

    // NOTE: every signal written here gets a value before any branch, so no latch can be inferred.
    always_comb begin
        elem_end = ELEM_DOWN[elem] ? (addr == '0) : (addr == ADDR_MAX);
        elem_nxt = (elem == E5) ? E0 : march_elem_e'(elem + 3'd1);
        last     = (elem == E5) && elem_end;
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            elem  <= E0;
            addr  <= '0;
            phase <= 1'b0;
        end else if (step) begin
            if (elem_ops(elem) == 2'd2 && !phase) begin
                phase <= 1'b1;
            end else begin
                phase <= 1'b0;
                if (elem_end) begin
                    elem <= elem_nxt;
                    addr <= ELEM_DOWN[elem_nxt] ? ADDR_MAX : '0;
                end else begin
                    addr <= ELEM_DOWN[elem] ? addr - ADDR_W'(1) : addr + ADDR_W'(1);
                end
            end
        end else if (restart) begin
            elem  <= E0;
            addr  <= '0;
            phase <= 1'b0;
        end
    end

endmodule

// File: rtl/ram_bist_ctrl.sv
// March C- BIST controller for the router FIFO RAM: issues one op per cycle,
// compares read data one cycle later and records the first mismatch.
module ram_bist_ctrl
    import ram_bist_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int WIDTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [2:0]        fail_elem,
    output logic              bist_en,
    output logic              bist_we,
    output logic [ADDR_W-1:0] bist_addr,
    output logic [WIDTH-1:0]  bist_wr_data,
    input  logic [WIDTH-1:0]  bist_rd_data
);

    state_e             state, state_d;
    logic               issue, mismatch, last_issued, seq_rd;
    march_elem_e        seq_elem, op_elem, cmp_elem;
    logic [ADDR_W-1:0]  seq_addr, cmp_addr;
    logic               seq_phase, seq_last;
    logic               op_exp, cmp_valid, cmp_exp;

    bist_march_seq #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_seq (
        .clk     (clk),
        .reset   (reset),
        .restart (!issue),
        .step    (issue),
        .elem    (seq_elem),
        .addr    (seq_addr),
        .phase   (seq_phase),
        .last    (seq_last)
    );

    always_comb begin
        state_d  = state;
        issue    = 1'b0;
        seq_rd   = ELEM_HAS_RD[seq_elem] && !seq_phase;
        mismatch = cmp_valid && (state == RUN || state == DRAIN)
                   && (bist_rd_data != {WIDTH{cmp_exp}});
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    issue   = 1'b1;
                end
            end
            RUN: begin
                if (mismatch)         state_d = DONE;
                else if (last_issued) state_d = DRAIN;
                else                  issue   = 1'b1;
            end
            DRAIN:   state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_d;
    end

    // Issue stage: the op presented to the macro, with its expected read polarity.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_issued  <= 1'b0;
            bist_en      <= 1'b0;
            bist_we      <= 1'b0;
            bist_addr    <= '0;
            bist_wr_data <= '0;
            op_elem      <= E0;
            op_exp       <= 1'b0;
        end else begin
            last_issued <= issue && seq_last;
            bist_en     <= issue;
            if (issue) begin
                bist_we      <= !seq_rd;
                bist_addr    <= seq_addr;
                bist_wr_data <= {WIDTH{ELEM_WR_POL[seq_elem]}};
                op_elem      <= seq_elem;
                op_exp       <= ELEM_RD_POL[seq_elem];
            end else begin
                bist_we <= 1'b0;
            end
        end
    end

    // Compare stage lines up with read data returning one cycle after the read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmp_valid <= 1'b0;
            cmp_exp   <= 1'b0;
            cmp_addr  <= '0;
            cmp_elem  <= E0;
        end else begin
            cmp_valid <= bist_en && !bist_we;
            cmp_exp   <= op_exp;
            cmp_addr  <= bist_addr;
            cmp_elem  <= op_elem;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_addr <= '0;
            fail_elem <= '0;
        end else begin
            busy <= (state_d == RUN) || (state_d == DRAIN);
            if (state_d == RUN && state != RUN) begin
                done      <= 1'b0;
                pass      <= 1'b0;
                fail_addr <= '0;
                fail_elem <= '0;
            end else if (state_d == DONE && state != DONE) begin
                done <= 1'b1;
                pass <= !mismatch;
                if (mismatch) begin
                    fail_addr <= cmp_addr;
                    fail_elem <= cmp_elem;
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Scoreboard bench for ram_bist_ctrl: 4x64 instance with a stuck-bit RAM model
// plus an 8-deep instance; expected March C- ops and results are queued up front.
module tb_ram_bist_ctrl;

    typedef struct {
        logic        we;
        int          addr;
        logic [63:0] data;
        int          k;
    } op_t;

    typedef struct {
        logic pass;
        int   fail_addr;
        int   fail_elem;
        int   done_rel;
    } res_t;

    localparam bit DN [6] = '{0, 0, 0, 1, 1, 0};
    localparam bit WP [6] = '{0, 1, 0, 1, 0, 0};

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        start4, busy4, done4, pass4, bist_en4, bist_we4;
    logic [1:0]  fail_addr4, bist_addr4;
    logic [2:0]  fail_elem4;
    logic [63:0] bist_wr_data4, rd4;

    logic        start8, busy8, done8, pass8, bist_en8, bist_we8;
    logic [2:0]  fail_addr8, bist_addr8;
    logic [2:0]  fail_elem8;
    logic [63:0] bist_wr_data8, rd8;

    ram_bist_ctrl #(.DEPTH(4), .WIDTH(64)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .busy(busy4), .done(done4),
        .pass(pass4), .fail_addr(fail_addr4), .fail_elem(fail_elem4),
        .bist_en(bist_en4), .bist_we(bist_we4), .bist_addr(bist_addr4),
        .bist_wr_data(bist_wr_data4), .bist_rd_data(rd4)
    );

    ram_bist_ctrl #(.DEPTH(8), .WIDTH(64)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .busy(busy8), .done(done8),
        .pass(pass8), .fail_addr(fail_addr8), .fail_elem(fail_elem8),
        .bist_en(bist_en8), .bist_we(bist_we8), .bist_addr(bist_addr8),
        .bist_wr_data(bist_wr_data8), .bist_rd_data(rd8)
    );

    // RAM models; faults are applied on the read path only.
    logic [63:0] mem4 [4];
    logic [63:0] sa0_4 [4];
    logic [63:0] sa1_4 [4];
    logic [63:0] mem8 [8];

    always @(posedge clk) begin
        if (bist_en4) begin
            if (bist_we4) mem4[bist_addr4] <= bist_wr_data4;
            else rd4 <= (mem4[bist_addr4] & ~sa0_4[bist_addr4]) | sa1_4[bist_addr4];
        end
        if (bist_en8) begin
            if (bist_we8) mem8[bist_addr8] <= bist_wr_data8;
            else rd8 <= mem8[bist_addr8];
        end
    end

    op_t  q4[$], q8[$];
    res_t r4[$], r8[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   t0_4 = 0;
    int   t0_8 = 0;
    logic done4_q = 1'b0;
    logic done8_q = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Op k of a fault-free March C- run on a depth-word RAM.
    function automatic op_t march_op(input int depth, input int k);
        op_t o;
        int  r;
        int  a;
        o.k    = k;
        o.data = '0;
        r      = k;
        if (r < depth) begin
            o.we   = 1'b1;
            o.addr = r;
            return o;
        end
        r -= depth;
        for (int e = 1; e <= 4; e++) begin
            if (r < 2 * depth) begin
                a      = r / 2;
                o.addr = DN[e] ? depth - 1 - a : a;
                o.we   = (r % 2) == 1;
                o.data = WP[e] ? '1 : '0;
                return o;
            end
            r -= 2 * depth;
        end
        o.we   = 1'b0;
        o.addr = r;
        return o;
    endfunction

    // Monitor: pops expected ops on every bist_en cycle and results on each done rise.
    always @(negedge clk) begin
        op_t  e;
        res_t r;
        if (reset) begin
            done4_q <= 1'b0;
            done8_q <= 1'b0;
        end else begin
            if (bist_en4) begin
                if (q4.size() == 0) check("d4_extra_op", 64'(bist_en4), 64'd0);
                else begin
                    e = q4.pop_front();
                    check("d4_op_we", 64'(bist_we4), 64'(e.we));
                    check("d4_op_addr", 64'(bist_addr4), 64'(e.addr));
                    if (e.we) check("d4_op_data", bist_wr_data4, e.data);
                    check("d4_op_cycle", 64'(cyc - t0_4), 64'(e.k));
                end
            end
            if (done4 && !done4_q) begin
                if (r4.size() == 0) check("d4_extra_done", 64'(done4), 64'd0);
                else begin
                    r = r4.pop_front();
                    check("d4_pass", 64'(pass4), 64'(r.pass));
                    check("d4_fail_addr", 64'(fail_addr4), 64'(r.fail_addr));
                    check("d4_fail_elem", 64'(fail_elem4), 64'(r.fail_elem));
                    check("d4_done_cycle", 64'(cyc - t0_4 + 1), 64'(r.done_rel));
                    check("d4_busy_at_done", 64'(busy4), 64'd0);
                end
            end
            if (bist_en8) begin
                if (q8.size() == 0) check("d8_extra_op", 64'(bist_en8), 64'd0);
                else begin
                    e = q8.pop_front();
                    check("d8_op_we", 64'(bist_we8), 64'(e.we));
                    check("d8_op_addr", 64'(bist_addr8), 64'(e.addr));
                    check("d8_op_cycle", 64'(cyc - t0_8), 64'(e.k));
                end
            end
            if (done8 && !done8_q) begin
                if (r8.size() == 0) check("d8_extra_done", 64'(done8), 64'd0);
                else begin
                    r = r8.pop_front();
                    check("d8_pass", 64'(pass8), 64'(r.pass));
                    check("d8_done_cycle", 64'(cyc - t0_8 + 1), 64'(r.done_rel));
                end
            end
            done4_q <= done4;
            done8_q <= done8;
        end
    end

    task automatic expect4(input int n_ops, input logic p, input int fa, input int fe, input int dn);
        res_t r;
        for (int k = 0; k < n_ops; k++) q4.push_back(march_op(4, k));
        r.pass = p; r.fail_addr = fa; r.fail_elem = fe; r.done_rel = dn;
        r4.push_back(r);
    endtask

    task automatic start_run4(input int hold);
        @(negedge clk);
        start4 = 1'b1;
        t0_4   = cyc + 1;
        repeat (hold) @(negedge clk);
        start4 = 1'b0;
    endtask

    task automatic finish4();
        int n;
        n = 0;
        while (!done4 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("d4_done_seen", 64'(done4), 64'd1);
        repeat (4) @(negedge clk);
        check("d4_ops_left", 64'(q4.size()), 64'd0);
        check("d4_res_left", 64'(r4.size()), 64'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"}, 64'(busy4), 64'd0);
        check({tag, "_done"}, 64'(done4), 64'd0);
        check({tag, "_pass"}, 64'(pass4), 64'd0);
        check({tag, "_fail_addr"}, 64'(fail_addr4), 64'd0);
        check({tag, "_fail_elem"}, 64'(fail_elem4), 64'd0);
        check({tag, "_bist_en"}, 64'(bist_en4), 64'd0);
        check({tag, "_bist_we"}, 64'(bist_we4), 64'd0);
        check({tag, "_bist_addr"}, 64'(bist_addr4), 64'd0);
        check({tag, "_bist_wr_data"}, bist_wr_data4, 64'd0);
    endtask

    initial begin
        int n;
        start4 = 1'b0;
        start8 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sa0_4[i] = '0;
            sa1_4[i] = '0;
        end
        repeat (2) @(negedge clk);
        check_reset_vals("por");
        reset = 1'b0;
        @(negedge clk);

        // Fault-free run: 40 ops, done/pass at T0+42.
        expect4(40, 1'b1, 0, 0, 42);
        start_run4(1);
        finish4();

        // Bit 17 of address 2 stuck-at-0: caught by E2 r1 at addr 2 (op 16).
        sa0_4[2] = 64'd1 << 17;
        expect4(18, 1'b0, 2, 2, 19);
        start_run4(1);
        finish4();
        sa0_4[2] = '0;

        // Bit 63 of address 3 stuck-at-1: caught by E1 r0 at addr 3 (op 10).
        sa1_4[3] = 64'd1 << 63;
        expect4(12, 1'b0, 3, 1, 13);
        start_run4(1);
        finish4();
        sa1_4[3] = '0;

        // Restart from DONE after a fail: result fields clear the next cycle.
        expect4(40, 1'b1, 0, 0, 42);
        start_run4(1);
        check("rerun_done_clr", 64'(done4), 64'd0);
        check("rerun_pass_clr", 64'(pass4), 64'd0);
        check("rerun_fail_addr_clr", 64'(fail_addr4), 64'd0);
        check("rerun_fail_elem_clr", 64'(fail_elem4), 64'd0);
        check("rerun_busy", 64'(busy4), 64'd1);
        finish4();

        // start held high through the whole RUN phase must not restart.
        expect4(40, 1'b1, 0, 0, 42);
        start_run4(41);
        finish4();

        // Reset in the middle of E3 (op 22), then a clean rerun.
        expect4(40, 1'b1, 0, 0, 42);
        start_run4(1);
        repeat (21) @(negedge clk);
        #2 reset = 1'b1;
        #1 check_reset_vals("midrst");
        q4.delete();
        r4.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        expect4(40, 1'b1, 0, 0, 42);
        start_run4(1);
        finish4();

        // DEPTH=8: 80 ops, E3 addresses 7 down to 0, done at T0+82.
        for (int k = 0; k < 80; k++) q8.push_back(march_op(8, k));
        begin
            res_t r;
            r.pass = 1'b1; r.fail_addr = 0; r.fail_elem = 0; r.done_rel = 82;
            r8.push_back(r);
        end
        @(negedge clk);
        start8 = 1'b1;
        t0_8   = cyc + 1;
        @(negedge clk);
        start8 = 1'b0;
        n = 0;
        while (!done8 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("d8_done_seen", 64'(done8), 64'd1);
        repeat (4) @(negedge clk);
        check("d8_ops_left", 64'(q8.size()), 64'd0);
        check("d8_res_left", 64'(r8.size()), 64'd0);
        check("d8_fail_addr", 64'(fail_addr8), 64'd0);
        check("d8_fail_elem", 64'(fail_elem8), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete (vectors %0d)", n_vec);
        $fatal(1);
    end

endmodule

// File: doc/ram_bist_ctrl.md
# ram_bist_ctrl

Built-in self-test controller for the router FIFO storage macro (DEPTH×WIDTH RAM, default 4×64). It drives the macro's BIST port and runs a March C- sequence with an all-zeros / all-ones data background. It reports pass/fail plus the first failing address and march element. It sits beside each FIFO instance in the router and is started by the chip test-control block.

## Interface
- DEPTH, 4: RAM words; power of two, ≥2.
- WIDTH, 64: RAM word width.
- ADDR_W, $clog2(DEPTH): BIST address width.

Ports:
- clk  in  1  single clock; also drives the macro BIST clock.
- reset  in  1  asynchronous, active-high.
- start  in  1  begin test; sampled only in IDLE or DONE.
- busy  out  1  test in progress.
- done  out  1  test finished; held until next start or reset.
- pass  out  1  valid when done=1; 1 = no mismatch.
- fail_addr  out  ADDR_W  address of the first mismatch; 0 if pass.
- fail_elem  out  3  march element index (0–5) of the first mismatch; 0 if pass.
- bist_en  out  1  macro BIST access enable.
- bist_we  out  1  1 = write, 0 = read; meaningful only when bist_en=1.
- bist_addr  out  ADDR_W  macro address.
- bist_wr_data  out  WIDTH  write data, all-0 or all-1.
- bist_rd_data  in  WIDTH  read data, valid the cycle after a read op.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- The 6 march elements, with address direction and ops per address:
  - E0: up, w0.
  - E1: up, r0 then w1.
  - E2: up, r1 then w0.
  - E3: down, r0 then w1.
  - E4: down, r1 then w0.
  - E5: up, r0.
- Total ops = 10·DEPTH; one op per cycle; no idle cycles between ops or elements.
- "up" runs address 0→DEPTH-1; "down" runs DEPTH-1→0. The address counter wraps to the start value of the next element's direction.
- Read compare: each read registers its expected value (all-0 or all-1), address and element. On the next cycle, bist_rd_data is compared to the expected value over all WIDTH bits.
- First mismatch: latch fail_addr and fail_elem, go to DONE with pass=0. The op issued in the compare cycle still completes; nothing further is issued.
- No mismatch: after the last op, go to DRAIN (bist_en=0, final compare), then DONE with pass=1.
- Transitions:
  - IDLE→RUN on start.
  - DONE→RUN on start; done, pass, fail_addr and fail_elem clear on entry to RUN.
  - start in RUN or DRAIN is ignored.

## Timing
- Reset values: busy=0, done=0, pass=0, fail_addr=0, fail_elem=0, bist_en=0, bist_we=0, bist_addr=0, bist_wr_data=0.
- All outputs are registered. bist_en drops asynchronously on reset, including mid-test; no state survives reset.
- start is sampled high at edge T0. The first op (E0 write, addr 0) is presented in cycle T0+1.
- busy=1 from T0+1 through the DRAIN cycle.
- Pass case: op k (k=0..10·DEPTH-1) is presented in cycle T0+1+k. DRAIN is cycle T0+1+10·DEPTH. done=1 and pass=1 from T0+2+10·DEPTH. For DEPTH=4: 40 op cycles, done at T0+42.
- Fail case: a read is presented in cycle R and its compare happens in cycle R+1. done=1, pass=0 and busy=0 from R+2; bist_en=0 from R+2.
- Within a read-then-write pair the write goes to the same address in the following cycle.

## Structure
- Package ram_bist_pkg holds:
  - the march element enum (E0–E5);
  - per-element direction, read polarity and write polarity constants;
  - the op count per element;
  - the FSM state enum.
- Sub-module bist_march_seq generates element index, address, op phase and last-op flag. ram_bist_ctrl contains the FSM, the compare pipeline and the result registers.

## Test plan
- Fault-free 4×64 model, start pulse at T0:
  - exactly 40 bist_en cycles;
  - op sequence matches March C-;
  - done=1, pass=1 at T0+42;
  - fail_addr=0, fail_elem=0.
- Bit 17 of address 2 stuck-at-0:
  - first mismatch on E2 r1 at addr 2;
  - pass=0, fail_addr=2, fail_elem=2;
  - done two cycles after that read;
  - no bist_en after done.
- Bit 63 of address 3 stuck-at-1: fail at E1 r0, addr 3; fail_elem=1, fail_addr=3.
- Reset asserted during element E3:
  - bist_en=0 and busy=0 immediately;
  - all outputs at reset values;
  - a fresh start then runs a full passing test.
- Start behaviour:
  - start held high throughout RUN causes no restart;
  - start pulsed in DONE after a fail clears done, pass and fail fields the next cycle and reruns to pass=1 with the fault removed.
- DEPTH=8 parameterisation: 80 op cycles, done at T0+82; E3 addresses run 7→0.
